mpm_port_driver: RTL
====================

# mpm_port_driver

Client-side initiator for the LVT multi-port memory. Accepts independent read/write requests on PORTS valid/ready channels, drives the memory's per-port `addr`/`en`/`d` buses, captures `q` after the fixed read latency and returns read data on per-port valid/ready response channels. It provides flow control, so read data is never dropped. It also resolves same-cycle address collisions between ports, so results never depend on memory-internal undefined behaviour.

## Interface
- `WIDTH`, 32, data width.
- `DEPTH`, 256, memory words; address width is `$clog2(DEPTH)`.
- `PORTS`, 4, port count (≥2), equal to the memory's PORTS.
- `READ_LATENCY`, 1, cycles from issued address to valid `mem_q`.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid[PORTS]`  in  1  request present.
- `req_ready[PORTS]`  out  1  request accepted this cycle when valid&ready.
- `req_write[PORTS]`  in  1  1 = write, 0 = read.
- `req_addr[PORTS]`  in  $clog2(DEPTH)  word address.
- `req_data[PORTS]`  in  WIDTH  write data.
- `rsp_valid[PORTS]`  out  1  read data available.
- `rsp_ready[PORTS]`  in  1  consumer takes response.
- `rsp_data[PORTS]`  out  WIDTH  read data, in request order per port.
- `mem_addr[PORTS]`  out  $clog2(DEPTH)  to memory `addr`.
- `mem_en[PORTS]`  out  1  to memory `en`; write strobe.
- `mem_d[PORTS]`  out  WIDTH  to memory `d`.
- `mem_q[PORTS]`  in  WIDTH  from memory `q`.
- `stall_count[PORTS]`  out  16  collision-stall counter (see Configuration).

## Operation
- Issue: port k issues when `req_valid[k] && req_ready[k]`.
- `mem_addr[k] = req_addr[k]` and `mem_d[k] = req_data[k]` combinationally.
- `mem_en[k] = issue[k] && req_write[k]`.
- Credits: each port has a response FIFO of depth R = READ_LATENCY+2 and a credit counter, which resets to R.
  - A read issue decrements the credit counter; a response pop increments it. A simultaneous issue and pop leave it unchanged.
  - Writes use no credit.
- Readiness: `req_ready[k] = !rst && !collide[k] && (req_write[k] || credit[k] != 0)`. `req_ready[k]` may depend combinationally on `req_write`, `req_addr` and `req_valid` of ports ≤ k.
- Collision: `collide[k] = 1` when, for some j < k, port j issues this cycle to the same address and at least one of j or k is a write. Lower index always wins.
  - The stalled port retries next cycle.
  - A stalled read therefore returns post-write data.
  - Two colliding reads do not stall.
- Read pipeline: each port has a READ_LATENCY-stage valid shift register. When a stage exits, `mem_q[k]` is pushed into the FIFO. The push is never blocked, because credits guarantee space.
- Responses: `rsp_valid[k]` = FIFO non-empty; `rsp_data[k]` = FIFO head. A pop occurs on `rsp_valid && rsp_ready`.
- Ports are fully independent apart from collision stalls.
- Per-port response order equals request order.

## Timing
- Reset values:
  - `req_ready` = 0 and `mem_en` = 0 while `rst` is high; `rsp_valid` = 0 in the cycle after `rst`.
  - FIFOs empty, pipelines clear, credits = R, `stall_count` = 0.
- Reset mid-operation discards in-flight reads and queued responses; nothing is returned afterwards.
- A read accepted at cycle t is captured at the end of cycle t+READ_LATENCY. `rsp_valid` rises at t+READ_LATENCY+1.
- Throughput: 1 read per cycle per port with `rsp_ready` held high. With `rsp_ready` low, a port accepts exactly R reads and then deasserts `req_ready` for reads.
- A response pop at cycle t restores one credit, usable at t+1.
- Writes take effect at the memory on the issue cycle edge.

## Configuration
- `MPM_DRIVER_STATS_EN` defined: `stall_count[k]` increments on every cycle where `req_valid[k] && collide[k]`. It saturates at 16'hFFFF and clears on `rst`.
- Undefined: counters are not built; `stall_count` is tied to 0.

## Test plan
- Single-port write/read: port 0 writes 0xDEADBEEF @5, then reads @5. Required: `rsp_data[0]` = 0xDEADBEEF at issue+READ_LATENCY+1, exactly one `rsp_valid` pulse.
- Write-write collision: ports 0 and 2 write 0x11/0x22 @9 in the same cycle. Required: port 2 stalls 1 cycle; a later read @9 returns 0x22; `stall_count[2]` = 1 (with macro).
- Read-after-write collision: port 1 writes 0xA5 @3 while port 3 reads @3 (old value 0). Required: port 3 stalls 1 cycle and returns 0xA5.
- Backpressure: `rsp_ready[1]` = 0, port 1 streams reads @0..9. Required: exactly R accepted, then `req_ready[1]` = 0. After `rsp_ready` rises, all 10 reads return in order with correct data.
- Full throughput: all PORTS ports read distinct addresses every cycle for 100 cycles with `rsp_ready` = 1. Required: no stalls, 100 in-order responses per port.
- Reset mid-flight: assert `rst` one cycle after issuing 2 reads on port 0. Required: no `rsp_valid` afterwards; credit restored to R; the next read returns normally.

Source files
------------

// File: rtl/mpm_port_driver.sv
// mpm_port_driver: client-side initiator for the LVT multi-port memory.
// Each port takes read/write requests on a valid/ready channel and drives the
// memory's addr/en/d buses. Read data comes back from q after READ_LATENCY
// cycles and goes into a per-port response FIFO, which the consumer drains on
// a valid/ready channel. A per-port credit counter ensures a read is only
// issued when its FIFO slot is reserved, so returning data is never dropped.
// Same-cycle address collisions are resolved with fixed priority: the lower
// port index wins, and the higher port retries on the next cycle.
//
// Optional feature macro: MPM_DRIVER_STATS_EN
//   defined   -> per-port saturating 16-bit collision-stall counters
//   undefined -> stall_count is tied to zero
module mpm_port_driver #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 256,
  parameter int PORTS        = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PORTS-1:0]                req_valid,
  output logic [PORTS-1:0]                req_ready,
  input  logic [PORTS-1:0]                req_write,
  input  logic [PORTS*$clog2(DEPTH)-1:0]  req_addr,
  input  logic [PORTS*WIDTH-1:0]          req_data,
  output logic [PORTS-1:0]                rsp_valid,
  input  logic [PORTS-1:0]                rsp_ready,
  output logic [PORTS*WIDTH-1:0]          rsp_data,
  output logic [PORTS*$clog2(DEPTH)-1:0]  mem_addr,
  output logic [PORTS-1:0]                mem_en,
  output logic [PORTS*WIDTH-1:0]          mem_d,
  input  logic [PORTS*WIDTH-1:0]          mem_q,
  output logic [PORTS*16-1:0]             stall_count
);

  localparam int AW = $clog2(DEPTH);
  // Response FIFO depth: covers every read in flight plus two queued entries.
  localparam int R  = READ_LATENCY + 2;
  localparam int PW = $clog2(R);
  localparam int CW = $clog2(R + 1);

  // Advance a circular FIFO pointer. R need not be a power of two.
  function automatic logic [PW-1:0] f_ptr_next(input logic [PW-1:0] p);
    return (p == PW'(R - 1)) ? '0 : p + 1'b1;
  endfunction

  // Increment a 16-bit counter and hold it at all-ones.
  function automatic logic [15:0] f_sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [PORTS-1:0]        w_collide;
  logic [PORTS-1:0]        w_issue;
  logic [PORTS-1:0]        w_rd_issue;
  logic [PORTS-1:0]        w_push;
  logic [PORTS-1:0]        w_pop;

  logic [READ_LATENCY-1:0] r_rd_vld_p [PORTS];
  logic [CW-1:0]           r_credit   [PORTS];
  logic [CW-1:0]           r_count    [PORTS];
  logic [PW-1:0]           r_wptr     [PORTS];
  logic [PW-1:0]           r_rptr     [PORTS];
  logic [WIDTH-1:0]        r_fifo     [PORTS][R];

  // Collision detection and issue arbitration. Ports are resolved in index
  // order so that port k sees the final issue decisions of all ports below it.
  always_comb begin
    w_collide = '0;
    w_issue   = '0;
    req_ready = '0;
    for (int k = 0; k < PORTS; k++) begin
      for (int j = 0; j < k; j++) begin
        if (w_issue[j] &&
            (req_addr[j*AW +: AW] == req_addr[k*AW +: AW]) &&
            (req_write[j] || req_write[k])) begin
          w_collide[k] = 1'b1;
        end
      end
      req_ready[k] = !rst && !w_collide[k] &&
                     (req_write[k] || (r_credit[k] != '0));
      w_issue[k]   = req_valid[k] && req_ready[k];
    end
  end

  // The memory address and data buses follow the request channel directly.
  // Only writes pulse the enable.
  always_comb begin
    mem_addr   = req_addr;
    mem_d      = req_data;
    mem_en     = w_issue & req_write;
    w_rd_issue = w_issue & ~req_write;
  end

  // Response channel view: the FIFO head plus push and pop strobes.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    w_push    = '0;
    w_pop     = '0;
    for (int k = 0; k < PORTS; k++) begin
      rsp_valid[k]              = (r_count[k] != '0);
      rsp_data[k*WIDTH +: WIDTH] = r_fifo[k][r_rptr[k]];
      w_push[k]                 = r_rd_vld_p[k][READ_LATENCY-1];
      w_pop[k]                  = rsp_valid[k] && rsp_ready[k];
    end
  end

  // Read pipeline: a valid bit walks READ_LATENCY stages and marks when q is due.
  always_ff @(posedge clk) begin
    for (int k = 0; k < PORTS; k++) begin
      if (rst) begin
        r_rd_vld_p[k] <= '0;
      end else begin
        r_rd_vld_p[k][0] <= w_rd_issue[k];
        for (int s = 1; s < READ_LATENCY; s++) begin
          r_rd_vld_p[k][s] <= r_rd_vld_p[k][s-1];
        end
      end
    end
  end

  // Credit counters: a read issue reserves a FIFO slot and a pop releases one.
  always_ff @(posedge clk) begin
    for (int k = 0; k < PORTS; k++) begin
      if (rst) begin
        r_credit[k] <= CW'(R);
      end else begin
        case ({w_rd_issue[k], w_pop[k]})
          2'b10:   r_credit[k] <= r_credit[k] - CW'(1);
          2'b01:   r_credit[k] <= r_credit[k] + CW'(1);
          default: r_credit[k] <= r_credit[k];
        endcase
      end
    end
  end

  // FIFO control: pointers and occupancy. Reset discards queued responses.
  always_ff @(posedge clk) begin
    for (int k = 0; k < PORTS; k++) begin
      if (rst) begin
        r_wptr[k]  <= '0;
        r_rptr[k]  <= '0;
        r_count[k] <= '0;
      end else begin
        if (w_push[k]) r_wptr[k] <= f_ptr_next(r_wptr[k]);
        if (w_pop[k])  r_rptr[k] <= f_ptr_next(r_rptr[k]);
        case ({w_push[k], w_pop[k]})
          2'b10:   r_count[k] <= r_count[k] + CW'(1);
          2'b01:   r_count[k] <= r_count[k] - CW'(1);
          default: r_count[k] <= r_count[k];
        endcase
      end
    end
  end

  // FIFO storage: capture q when a read exits the pipeline. Credits guarantee
  // a free slot, so the push is never blocked.
  always_ff @(posedge clk) begin
    for (int k = 0; k < PORTS; k++) begin
      if (w_push[k]) begin
        r_fifo[k][r_wptr[k]] <= mem_q[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef MPM_DRIVER_STATS_EN
  logic [15:0] r_stall [PORTS];

  // Stall statistics: count every cycle a port presents a request but is held
  // off by a lower-index port.
  always_ff @(posedge clk) begin
    for (int k = 0; k < PORTS; k++) begin
      if (rst) begin
        r_stall[k] <= '0;
      end else if (req_valid[k] && w_collide[k]) begin
        r_stall[k] <= f_sat_inc16(r_stall[k]);
      end
    end
  end

  // Pack the counters onto the output bus.
  always_comb begin
    stall_count = '0;
    for (int k = 0; k < PORTS; k++) begin
      stall_count[k*16 +: 16] = r_stall[k];
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule
